// File: rtl/whack_pkg.sv
// Shared constants for the smash button conditioner: zone codes, arbiter states
// and the zone priority encoder.
package whack_pkg;

  localparam logic [1:0] ZONE_TL = 2'b00;
  localparam logic [1:0] ZONE_TR = 2'b01;
  localparam logic [1:0] ZONE_BL = 2'b10;
  localparam logic [1:0] ZONE_BR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HELD = 2'b01,
    ST_GAP  = 2'b10
  } arb_state_e;

  // Lowest-numbered pressed button wins: TL > TR > BL > BR.
  function automatic logic [1:0] zone_of(input logic [3:0] db);
    logic [1:0] z;
    if (db[0]) begin
      z = ZONE_TL;
    end else if (db[1]) begin
      z = ZONE_TR;
    end else if (db[2]) begin
      z = ZONE_BL;
    end else begin
      z = ZONE_BR;
    end
    return z;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer and debouncer for one active-low button.
// Outputs a registered, active-high debounced pressed level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500
) (
  input  logic clk100k,
  input  logic reset,
  input  logic btn_n,
  output logic btn_db
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pressed_s;

  // Next-state: shift the synchronizer, count consecutive mismatching samples.
  always_comb begin
    sync1_d   = btn_n;
    sync2_d   = sync1_q;
    pressed_s = ~sync2_q;
    db_d      = db_q;
    cnt_d     = {CW{1'b0}};
    if (pressed_s == db_q) begin
      cnt_d = {CW{1'b0}};
    end else if (cnt_q == CNT_LAST) begin
      db_d  = ~db_q;
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // State registers; synchronizer resets to the released level.
  always_ff @(posedge clk100k) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      db_q    <= 1'b0;
      cnt_q   <= {CW{1'b0}};
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_db = db_q;

endmodule

// File: rtl/smash_button_conditioner.sv
// Debounces four smash buttons and arbitrates one accepted press at a time,
// stretching smash_any high/low so the slow game clock sees each press cleanly.
module smash_button_conditioner
  import whack_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500,
  parameter int HOLD_CYCLES     = 1200,
  parameter int GAP_CYCLES      = 1200
) (
  input  logic       clk100k,
  input  logic       reset,
  input  logic [3:0] btn_n,
  output logic       smash_any,
  output logic [1:0] smash_zone,
  output logic       press_pulse,
  output logic [7:0] press_count,
  output logic [3:0] btn_db
);

  localparam int TMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);

  arb_state_e    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          smash_any_q, smash_any_d;
  logic          press_pulse_q, press_pulse_d;
  logic [7:0]    press_count_q, press_count_d;
  logic [1:0]    smash_zone_q, smash_zone_d;

  for (genvar g = 0; g < 4; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk100k(clk100k),
      .reset  (reset),
      .btn_n  (btn_n[g]),
      .btn_db (btn_db[g])
    );
  end

  // Arbiter next-state; one timer serves both the hold and the gap phase.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    smash_any_d   = smash_any_q;
    press_pulse_d = 1'b0;
    press_count_d = press_count_q;
    smash_zone_d  = smash_zone_q;
    case (state_q)
      ST_IDLE: begin
        if (btn_db != 4'b0000) begin
          state_d       = ST_HELD;
          smash_any_d   = 1'b1;
          press_pulse_d = 1'b1;
          press_count_d = press_count_q + 8'd1;
          smash_zone_d  = zone_of(btn_db);
          timer_d       = HOLD_LOAD;
        end else begin
          smash_any_d = 1'b0;
        end
      end
      ST_HELD: begin
        if (timer_q != {TW{1'b0}}) begin
          timer_d     = timer_q - TW'(1);
          smash_any_d = 1'b1;
        end else if (btn_db == 4'b0000) begin
          state_d     = ST_GAP;
          smash_any_d = 1'b0;
          timer_d     = GAP_LOAD;
        end else begin
          smash_any_d = 1'b1;
        end
      end
      ST_GAP: begin
        smash_any_d = 1'b0;
        if (timer_q != {TW{1'b0}}) begin
          timer_d = timer_q - TW'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        timer_d     = {TW{1'b0}};
        smash_any_d = 1'b0;
      end
    endcase
  end

  // Arbiter and output registers.
  always_ff @(posedge clk100k) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      timer_q       <= {TW{1'b0}};
      smash_any_q   <= 1'b0;
      press_pulse_q <= 1'b0;
      press_count_q <= 8'd0;
      smash_zone_q  <= ZONE_BR;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      smash_any_q   <= smash_any_d;
      press_pulse_q <= press_pulse_d;
      press_count_q <= press_count_d;
      smash_zone_q  <= smash_zone_d;
    end
  end

  assign smash_any   = smash_any_q;
  assign press_pulse = press_pulse_q;
  assign press_count = press_count_q;
  assign smash_zone  = smash_zone_q;

endmodule

// File: tb/tb_smash_button_conditioner.sv
// Scoreboard bench: a timestamp-based reference model predicts every cycle's
// outputs and each accepted press; a negedge monitor compares against the DUT.
module tb_smash_button_conditioner;

  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int GAP  = 6;

  logic       clk100k = 1'b0;
  logic       reset   = 1'b1;
  logic [3:0] btn_n   = 4'hF;
  logic       smash_any;
  logic [1:0] smash_zone;
  logic       press_pulse;
  logic [7:0] press_count;
  logic [3:0] btn_db;

  smash_button_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES    (HOLD),
    .GAP_CYCLES     (GAP)
  ) dut (
    .clk100k    (clk100k),
    .reset      (reset),
    .btn_n      (btn_n),
    .smash_any  (smash_any),
    .smash_zone (smash_zone),
    .press_pulse(press_pulse),
    .press_count(press_count),
    .btn_db     (btn_db)
  );

  always #5 clk100k = ~clk100k;

  typedef struct {
    logic       any;
    logic       pulse;
    logic [1:0] zone;
    logic [7:0] count;
    logic [3:0] db;
  } exp_t;

  typedef struct {
    logic [1:0] zone;
    logic [7:0] count;
  } press_t;

  exp_t   exp_q[$];
  press_t press_q[$];
  int     n_checks = 0;
  int     n_err    = 0;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h want %0h", name, $time, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  bit         s1[4], s2[4];
  bit         mdb[4];
  bit         win[4][$];
  int         phase;      // 0 idle, 1 held, 2 gap
  int         cyc;
  int         acc_edge, fall_edge;
  logic       m_any, m_pulse;
  logic [1:0] m_zone;
  logic [7:0] m_count;

  task automatic model_step();
    exp_t   e;
    press_t p;
    bit     any_db;
    bit     pr;
    bit     all_diff;
    cyc++;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        s1[i] = 1'b1; s2[i] = 1'b1; mdb[i] = 1'b0; win[i].delete();
      end
      phase = 0; m_any = 1'b0; m_pulse = 1'b0; m_zone = 2'b11; m_count = 8'd0;
    end else begin
      any_db  = mdb[0] | mdb[1] | mdb[2] | mdb[3];
      m_pulse = 1'b0;
      if (phase == 0) begin
        if (any_db) begin
          phase = 1; acc_edge = cyc; m_any = 1'b1; m_pulse = 1'b1;
          m_count = m_count + 8'd1;
          if (mdb[0]) m_zone = 2'd0;
          else if (mdb[1]) m_zone = 2'd1;
          else if (mdb[2]) m_zone = 2'd2;
          else m_zone = 2'd3;
          p.zone = m_zone; p.count = m_count;
          press_q.push_back(p);
        end
      end else if (phase == 1) begin
        if (cyc >= acc_edge + HOLD && !any_db) begin
          phase = 2; fall_edge = cyc; m_any = 1'b0;
        end
      end else begin
        if (cyc >= fall_edge + GAP) phase = 0;
      end
      // debounced level flips once the last DEB synced samples all disagree
      for (int i = 0; i < 4; i++) begin
        pr = ~s2[i];
        win[i].push_back(pr);
        if (win[i].size() > DEB) void'(win[i].pop_front());
        all_diff = (win[i].size() == DEB);
        foreach (win[i][k]) if (win[i][k] == mdb[i]) all_diff = 1'b0;
        if (all_diff) begin
          mdb[i] = ~mdb[i];
          win[i].delete();
        end
        s2[i] = s1[i];
        s1[i] = btn_n[i];
      end
    end
    e.any = m_any; e.pulse = m_pulse; e.zone = m_zone; e.count = m_count;
    e.db  = {mdb[3], mdb[2], mdb[1], mdb[0]};
    exp_q.push_back(e);
  endtask

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk100k);
      model_step();
    end
  end

  // ---------------- monitor ----------------
  initial begin
    exp_t   e;
    press_t p;
    forever begin
      @(negedge clk100k);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("smash_any",   {7'd0, smash_any},   {7'd0, e.any});
        chk("press_pulse", {7'd0, press_pulse}, {7'd0, e.pulse});
        chk("smash_zone",  {6'd0, smash_zone},  {6'd0, e.zone});
        chk("press_count", press_count,         e.count);
        chk("btn_db",      {4'd0, btn_db},      {4'd0, e.db});
      end
      if (press_pulse === 1'b1) begin
        if (press_q.size() == 0) begin
          chk("unexpected_press", 8'd1, 8'd0);
        end else begin
          p = press_q.pop_front();
          chk("press_zone",  {6'd0, smash_zone}, {6'd0, p.zone});
          chk("press_count_at_pulse", press_count, p.count);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk100k);
      #2;
    end
  endtask

  initial begin
    int hold_len;
    // reset with all buttons released
    reset = 1'b1; btn_n = 4'hF;
    cycles(10);
    reset = 1'b0;
    cycles(5);
    // BL press held 20 cycles
    btn_n = 4'b1011; cycles(20);
    btn_n = 4'hF;    cycles(30);
    // TL bounce every 2 cycles
    for (int i = 0; i < 6; i++) begin
      btn_n = (i % 2 == 0) ? 4'b1110 : 4'b1111;
      cycles(2);
    end
    btn_n = 4'hF; cycles(20);
    // BR and TR together, then TL during HELD
    btn_n = 4'b0101; cycles(10);
    btn_n = 4'b0100; cycles(6);
    btn_n = 4'hF;    cycles(40);
    // short TL press, re-press shortly after smash_any falls
    btn_n = 4'b1110; cycles(7);
    btn_n = 4'hF;    cycles(14);
    btn_n = 4'b1110; cycles(20);
    btn_n = 4'hF;    cycles(40);
    // reset mid-HELD with BR held
    btn_n = 4'b0111; cycles(10);
    reset = 1'b1;    cycles(2);
    reset = 1'b0;    cycles(20);
    btn_n = 4'hF;    cycles(40);
    // randomized presses, bounces and occasional resets
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) btn_n = 4'hF;
      else btn_n = 4'($urandom_range(0, 15));
      reset = ($urandom_range(0, 49) == 0);
      hold_len = $urandom_range(1, 15);
      cycles(hold_len);
      reset = 1'b0;
    end
    btn_n = 4'hF; reset = 1'b0;
    cycles(60);
    @(negedge clk100k);
    chk("press_queue_drained", 8'(press_q.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
